// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LoongArch MEM stage: waits for data-SRAM responses, extracts load data, feeds WB.
// Define MS_FWD_EN to drive the MEM->ID forwarding bus; otherwise that bus is tied to zero.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ms_stall,
    input  logic        ms_flush,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [73:0] es_to_ms_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [38:0] ms_to_is_forward_bus
);

    logic        ms_valid;
    logic [73:0] bus_r;
    logic        data_got;
    logic [31:0] rdata_buf;
    logic [1:0]  drop_cnt;

    logic        mem_req;
    logic        mem_re;
    logic [2:0]  mem_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign mem_req    = bus_r[73];
    assign mem_re     = bus_r[72];
    assign mem_op     = bus_r[71:69];
    assign gr_we      = bus_r[68];
    assign dest       = bus_r[67:63];
    assign alu_result = bus_r[62:31];
    assign pc         = {bus_r[30:0], 1'b0};

    logic data_ok_use;
    logic ms_ready_go;
    logic in_wait;
    logic drop_inc;
    logic drop_dec;

    // A response only belongs to the current entry once all stale ones are drained.
    assign data_ok_use    = data_sram_data_ok & (drop_cnt == 2'd0);
    assign ms_ready_go    = ~mem_req | data_got | data_ok_use;
    assign ms_allowin     = (~ms_valid | (ms_ready_go & ws_allowin)) & ~ms_stall;
    assign ms_to_ws_valid = ms_valid & ms_ready_go & ~ms_stall;
    assign in_wait        = ms_valid & mem_req & ~data_got;
    assign drop_inc       = ms_flush & in_wait & ~data_ok_use;
    assign drop_dec       = data_sram_data_ok & (drop_cnt != 2'd0);

    logic [31:0] word;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_data;
    logic [31:0] final_result;

    always_comb begin
        word = data_got ? rdata_buf : data_sram_rdata;
        case (alu_result[1:0])
            2'd0:    byte_val = word[7:0];
            2'd1:    byte_val = word[15:8];
            2'd2:    byte_val = word[23:16];
            default: byte_val = word[31:24];
        endcase
        half_val = alu_result[1] ? word[31:16] : word[15:0];
        case (mem_op[1:0])
            2'b01:   load_data = {{24{byte_val[7] & ~mem_op[2]}}, byte_val};
            2'b10:   load_data = {{16{half_val[15] & ~mem_op[2]}}, half_val};
            default: load_data = word;
        endcase
        final_result = mem_re ? load_data : alu_result;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid  <= 1'b0;
            bus_r     <= '0;
            data_got  <= 1'b0;
            rdata_buf <= '0;
            drop_cnt  <= 2'd0;
        end else begin
            if (ms_flush) begin
                ms_valid <= 1'b0;
                bus_r    <= '0;
                data_got <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
                if (es_to_ms_valid)
                    bus_r <= es_to_ms_bus;
                data_got <= 1'b0;
            end else if (in_wait & data_ok_use) begin
                // WB not accepting (or stalled): park the response so it is never needed twice.
                data_got  <= 1'b1;
                rdata_buf <= data_sram_rdata;
            end
            if (drop_inc & ~drop_dec)
                drop_cnt <= drop_cnt + 2'd1;
            else if (drop_dec & ~drop_inc)
                drop_cnt <= drop_cnt - 2'd1;
        end
    end

    assert property (@(posedge clk) disable iff (!resetn) drop_cnt != 2'd3);

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

`ifdef MS_FWD_EN
    logic fwd_en;
    logic ms_busy;
    assign fwd_en  = ms_valid & gr_we & (dest != 5'd0);
    assign ms_busy = ms_valid & mem_re & ~ms_ready_go;
    assign ms_to_is_forward_bus = {fwd_en, ms_busy, dest, final_result};
`else
    assign ms_to_is_forward_bus = 39'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized bench for mem_stage against a transaction-level model (MS_FWD_EN aware).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_stall = 1'b0;
    logic        ms_flush = 1'b0;
    logic        ms_allowin;
    logic        es_to_ms_valid = 1'b0;
    logic [73:0] es_to_ms_bus = '0;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;
    logic        ws_allowin = 1'b0;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] fwd_bus;

    mem_stage dut (
        .clk                  (clk),
        .resetn               (resetn),
        .ms_stall             (ms_stall),
        .ms_flush             (ms_flush),
        .ms_allowin           (ms_allowin),
        .es_to_ms_valid       (es_to_ms_valid),
        .es_to_ms_bus         (es_to_ms_bus),
        .data_sram_data_ok    (data_sram_data_ok),
        .data_sram_rdata      (data_sram_rdata),
        .ws_allowin           (ws_allowin),
        .ms_to_ws_valid       (ms_to_ws_valid),
        .ms_to_ws_bus         (ms_to_ws_bus),
        .ms_to_is_forward_bus (fwd_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem_req;
        logic        mem_re;
        logic [2:0]  op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
    } ent_t;

    typedef struct packed {
        logic [31:0] data;
        logic        killed;
    } resp_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    cur_valid = 1'b0;
    ent_t  cur = '0;
    bit    have_data = 1'b0;
    logic [31:0] held = '0;
    resp_t rq[$];

    task automatic check_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input bit req, input bit re, input logic [2:0] op, input bit we,
                                input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
        ent_t e;
        e.mem_req = req; e.mem_re = re; e.op = op; e.gr_we = we;
        e.dest = dest; e.alu = alu; e.pc = pc;
        return e;
    endfunction

    function automatic logic [73:0] pack(input ent_t e);
        return {e.mem_req, e.mem_re, e.op, e.gr_we, e.dest, e.alu, e.pc[31:1]};
    endfunction

    // Loads: pick the addressed byte/half by shifting, then extend by op[2].
    function automatic logic [31:0] load_value(input ent_t e, input logic [31:0] w);
        int width;
        int shift;
        logic [31:0] mask;
        logic [31:0] v;
        if (!e.mem_re) return e.alu;
        if (e.op[1:0] == 2'b01) begin
            width = 8;  shift = 8 * int'(e.alu[1:0]);
        end else if (e.op[1:0] == 2'b10) begin
            width = 16; shift = 16 * int'(e.alu[1]);
        end else begin
            return w;
        end
        mask = (32'd1 << width) - 32'd1;
        v = (w >> shift) & mask;
        if (!e.op[2] && v[width-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        logic [31:0] t;
        e.mem_req = 1'($urandom_range(0, 1));
        e.mem_re  = e.mem_req & 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0: e.op = 3'b000;
            1: e.op = 3'b001;
            2: e.op = 3'b010;
            3: e.op = 3'b101;
            default: e.op = 3'b110;
        endcase
        e.gr_we = 1'($urandom_range(0, 1));
        e.dest  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        e.alu   = $urandom;
        t = $urandom;
        t[0] = 1'b0;
        e.pc = t;
        return e;
    endfunction

    task automatic step(input bit stall, input bit flush, input bit wsa, input bit esv,
                        input ent_t e, input bit dok, input logic [31:0] resp);
        bit ready, exp_valid, exp_allow, use_now;
        logic [31:0] word, fr;
        resp_t front, r;
`ifdef MS_FWD_EN
        bit fwd_en, busy;
`endif
        @(negedge clk);
        dok = dok && (rq.size() > 0);
        if (flush) begin
            e.mem_req = 1'b0;
            e.mem_re  = 1'b0;
        end
        ms_stall          = stall;
        ms_flush          = flush;
        ws_allowin        = wsa;
        es_to_ms_valid    = esv;
        es_to_ms_bus      = pack(e);
        data_sram_data_ok = dok;
        data_sram_rdata   = dok ? rq[0].data : $urandom;
        #1;
        front     = dok ? rq[0] : '0;
        use_now   = dok && !front.killed;
        ready     = cur_valid && (!cur.mem_req || have_data || use_now);
        exp_valid = ready && !stall;
        exp_allow = (!cur_valid || (ready && wsa)) && !stall;
        check_eq("ms_to_ws_valid", 70'(ms_to_ws_valid), 70'(exp_valid));
        check_eq("ms_allowin", 70'(ms_allowin), 70'(exp_allow));
        word = have_data ? held : front.data;
        fr   = load_value(cur, word);
        if (exp_valid)
            check_eq("ms_to_ws_bus", ms_to_ws_bus, {cur.gr_we, cur.dest, fr, cur.pc});
`ifdef MS_FWD_EN
        fwd_en = cur_valid && cur.gr_we && (cur.dest != 5'd0);
        busy   = cur_valid && cur.mem_re && !ready;
        check_eq("fwd_flags", 70'(fwd_bus[38:37]), 70'({fwd_en, busy}));
        if (cur_valid && (ready || !cur.mem_re))
            check_eq("fwd_data", 70'(fwd_bus[36:0]), 70'({cur.dest, fr}));
`else
        check_eq("fwd_tied", 70'(fwd_bus), 70'd0);
`endif
        // Model the clock edge: consume the response, then flush / hold / advance.
        if (dok) begin
            void'(rq.pop_front());
            if (use_now) begin
                have_data = 1'b1;
                held = front.data;
            end
        end
        if (flush) begin
            foreach (rq[i]) rq[i].killed = 1'b1;
            cur_valid = 1'b0;
            cur       = '0;
            have_data = 1'b0;
        end else if (exp_allow) begin
            cur_valid = esv;
            have_data = 1'b0;
            if (esv) begin
                cur = e;
                if (e.mem_req) begin
                    r.data   = resp;
                    r.killed = 1'b0;
                    rq.push_back(r);
                end
            end
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        ms_stall = 1'b0; ms_flush = 1'b0; data_sram_data_ok = 1'b0; es_to_ms_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_valid", 70'(ms_to_ws_valid), 70'd0);
        check_eq("rst_ws_bus", ms_to_ws_bus, 70'd0);
        check_eq("rst_fwd_bus", 70'(fwd_bus), 70'd0);
        rq.delete();
        cur_valid = 1'b0; cur = '0; have_data = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b1;
        #1 check_eq("rst_allowin", 70'(ms_allowin), 70'd1);
    endtask

    ent_t z = '0;

    initial begin : main
        bit st, fl, wa, ev, dk;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        check_eq("reset_valid", 70'(ms_to_ws_valid), 70'd0);
        check_eq("reset_allowin", 70'(ms_allowin), 70'd1);
        check_eq("reset_ws_bus", ms_to_ws_bus, 70'd0);
        check_eq("reset_fwd_bus", 70'(fwd_bus), 70'd0);
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;

        step(0, 0, 1, 1, mk(0, 0, 3'b000, 1, 5'd5, 32'h12345678, 32'h1c000000), 0, 32'h0);
        step(0, 0, 1, 0, z, 0, 32'h0);
        check_eq("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h12345678, 32'h1c000000});

        step(0, 0, 1, 1, mk(1, 1, 3'b001, 1, 5'd9, 32'h10000003, 32'h1c000010), 0, 32'h80FF0000);
        step(0, 0, 1, 0, z, 1, 32'h0);
        check_eq("ld_b_result", 70'(ms_to_ws_bus[63:32]), 70'h0FFFFFF80);
        step(0, 0, 1, 1, mk(1, 1, 3'b110, 1, 5'd9, 32'h10000002, 32'h1c000014), 0, 32'h80FF0000);
        step(0, 0, 1, 0, z, 1, 32'h0);
        check_eq("ld_hu_result", 70'(ms_to_ws_bus[63:32]), 70'h0000080FF);

        step(0, 0, 1, 1, mk(1, 1, 3'b000, 1, 5'd3, 32'h10000000, 32'h1c000018), 0, 32'hCAFEF00D);
        step(0, 0, 0, 0, z, 1, 32'h0);
        step(0, 0, 0, 0, z, 0, 32'h0);
        step(0, 0, 0, 0, z, 0, 32'h0);
        check_eq("bp_allowin", 70'(ms_allowin), 70'd0);
        step(0, 0, 1, 0, z, 0, 32'h0);
        check_eq("bp_data", 70'(ms_to_ws_bus[63:32]), 70'hCAFEF00D);

        step(0, 0, 1, 1, mk(1, 1, 3'b000, 1, 5'd4, 32'h10000004, 32'h1c00001c), 0, 32'hDEADBEEF);
        step(0, 1, 1, 0, z, 0, 32'h0);
        step(0, 0, 1, 1, mk(1, 1, 3'b000, 1, 5'd6, 32'h10000008, 32'h1c000020), 0, 32'h00000042);
        step(0, 0, 1, 0, z, 1, 32'h0);
        check_eq("drop_stale", 70'(ms_to_ws_valid), 70'd0);
        step(0, 0, 1, 0, z, 1, 32'h0);
        check_eq("flush_new_load", 70'(ms_to_ws_bus[63:32]), 70'h00000042);

        step(0, 0, 1, 1, mk(1, 1, 3'b000, 1, 5'd7, 32'h1000000c, 32'h1c000024), 0, 32'h00001234);
        step(0, 0, 1, 0, z, 0, 32'h0);
`ifdef MS_FWD_EN
        check_eq("fwd_pending", 70'(fwd_bus[38:32]), 70'({1'b1, 1'b1, 5'd7}));
        step(0, 0, 1, 0, z, 1, 32'h0);
        check_eq("fwd_done", 70'(fwd_bus[38:0]), 70'({1'b1, 1'b0, 5'd7, 32'h00001234}));
`else
        check_eq("fwd_off_pending", 70'(fwd_bus), 70'd0);
        step(0, 0, 1, 0, z, 1, 32'h0);
        check_eq("fwd_off_done", 70'(fwd_bus), 70'd0);
`endif

        step(0, 0, 1, 1, mk(1, 1, 3'b000, 1, 5'd8, 32'h10000010, 32'h1c000028), 0, 32'h55AA55AA);
        mid_reset();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                mid_reset();
            end else begin
                st = ($urandom_range(0, 7) == 0);
                fl = (rq.size() <= 2) && ($urandom_range(0, 15) == 0);
                wa = ($urandom_range(0, 9) < 7);
                ev = ($urandom_range(0, 9) < 6);
                dk = ($urandom_range(0, 9) < 4);
                step(st, fl, wa, ev, rand_ent(), dk, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
